alu_serial_seq: RTL and testbench
=================================

# alu_serial_seq

Bit-serial sequencer that runs a full-width ALU operation through one ALU bit slice, one bit per clock, LSB first. It is the operand-producer / result-consumer side of the slice interface, issuing a_i/b_i/c_i/invert_i/less_i/operacion_i per bit and collecting resultado_o/c_o/set_o. It gives the monocycle datapath an area-small ALU path behind a valid/ready handshake, with the same operation encoding as the slice.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept a request; high only in IDLE.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- invert_i  input  1  invert B and force carry-in to 1 (subtract); ignored for SLT, which always inverts.
- operacion_i  input  3  000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 XOR, others produce result 0.
- valid_o  output  1  one-cycle pulse: result registers updated.
- resultado_o  output  WIDTH  result; held until next completion.
- zero_o  output  1  resultado_o == 0.
- carry_o  output  1  carry out of MSB; 0 for AND/OR/XOR/unused opcodes.
- overflow_o  output  1  signed overflow; see Configuration.

## Operation
- Reset (async, rst_ni low): state IDLE, ready_o=1, valid_o=0, resultado_o=0, zero_o=0, carry_o=0, overflow_o=0, bit counter 0.
- Acceptance: rising edge with valid_i=1 and ready_o=1. Operands, opcode and effective invert are captured into internal registers; later input changes have no effect.
- Effective invert = 1 for SLT, invert_i otherwise. Carry register initialised to effective invert.
- States: IDLE -> RUN on acceptance; RUN -> DONE after WIDTH bit cycles; DONE -> IDLE unconditionally after one cycle.
- RUN, bit k (k = 0..WIDTH-1): b bit inverted if effective invert; AND/OR/XOR/sum computed on (a[k], b'[k], carry); the carry register takes the carry out; the selected bit is shifted into an internal accumulator, never into resultado_o directly.
- SLT: all WIDTH bits run as A − B; final result = {WIDTH-1 zeros, sum MSB}. No overflow correction (MSB of difference, matching slice set_o semantics).
- Unused opcodes: full WIDTH cycles, result 0, carry_o 0, overflow_o 0.
- Entering DONE: accumulator copied to resultado_o, zero_o/carry_o/overflow_o updated, valid_o=1 for that cycle.
- valid_i while not in IDLE: ignored, not queued; requester must hold until ready_o.
- Reset mid-operation: immediate abort to IDLE; resultado_o and flags cleared; no valid_o pulse.

## Timing
- Acceptance at edge T0; RUN occupies cycles T0..T0+WIDTH-1 (bit k processed in the cycle after edge T0+k); state DONE and valid_o=1 in the cycle following edge T0+WIDTH.
- Latency: valid_o rises WIDTH edges after acceptance; ready_o returns one edge later. Throughput: one op per WIDTH+2 cycles.
- ready_o and valid_o are registered state decodes; no combinational path from valid_i to ready_o.
- Bit counter width clog2(WIDTH); terminal count WIDTH-1, no wrap beyond.

## Configuration
- ALU_SERIAL_OVF_EN defined: overflow_o = carry into MSB XOR carry out of MSB for ADD/SUB and SLT; 0 for other opcodes. One extra flop holds carry-into-MSB.
- Not defined: overflow_o tied to 0; carry-into-MSB flop omitted.

## Test plan
- Reset asserted then released: ready_o=1, valid_o=0, resultado_o=0, all flags 0; reset pulse mid-cycle takes effect without a clock edge.
- WIDTH=32, ADD 5 + 7 (invert_i=0): valid_o exactly 32 edges after acceptance, resultado_o=12, zero_o=0, carry_o=0.
- SUB 0x80000000 − 1 (invert_i=1): resultado_o=0x7FFFFFFF, carry_o=1, overflow_o=1 with ALU_SERIAL_OVF_EN, 0 without; SUB 9−9 gives 0, zero_o=1.
- SLT 3,5 -> resultado_o=1; SLT 5,3 -> 0; AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; XOR same -> 0x0FF00FF0; opcode 111 -> 0, zero_o=1.
- valid_i held high continuously with changing operands: exactly one acceptance per WIDTH+2 cycles, each result matches operands sampled at its acceptance edge.
- rst_ni low at bit cycle 10 of an ADD: ready_o=1 immediately, no valid_o pulse, resultado_o=0; next request completes correctly.

Source files
------------

// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between a requester and the bit-serial ALU sequencer.
interface alu_serial_seq_if #(parameter int unsigned WIDTH = 32);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             invert_i;
  logic [2:0]       operacion_i;
  logic             valid_o;
  logic [WIDTH-1:0] resultado_o;
  logic             zero_o;
  logic             carry_o;
  logic             overflow_o;

  modport master (
    output valid_i, a_i, b_i, invert_i, operacion_i,
    input  ready_o, valid_o, resultado_o, zero_o, carry_o, overflow_o
  );

  modport slave (
    input  valid_i, a_i, b_i, invert_i, operacion_i,
    output ready_o, valid_o, resultado_o, zero_o, carry_o, overflow_o
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one operand bit per clock through a single slice, LSB first.
// Optional signed-overflow output enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk_i,
  input logic            rst_ni,
  alu_serial_seq_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_XOR = 3'b100
  } op_e;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [2:0]       op_q;
  logic             inv_q, carry_q, zero_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic             last, a_bit, b_bit, sum, cout, sel, arith;
  logic [WIDTH-1:0] acc_nxt, res_fin;

  always_comb begin
    last    = (cnt_q == CW'(WIDTH - 1));
    a_bit   = a_q[0];
    b_bit   = b_q[0] ^ inv_q;
    sum     = a_bit ^ b_bit ^ carry_q;
    cout    = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    arith   = (op_q == OP_ADD) || (op_q == OP_SLT);
    sel     = 1'b0;
    case (op_q)
      OP_AND:  sel = a_bit & b_bit;
      OP_OR:   sel = a_bit | b_bit;
      OP_ADD:  sel = sum;
      OP_SLT:  sel = sum;
      OP_XOR:  sel = a_bit ^ b_bit;
      default: sel = 1'b0;
    endcase
    acc_nxt = {sel, acc_q[WIDTH-1:1]};
    res_fin = acc_nxt;
    // SLT keeps only the sign of A-B, which is the sum bit of the final (MSB) cycle.
    if (op_q == OP_SLT) begin
      res_fin    = '0;
      res_fin[0] = sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid_i) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            op_q    <= bus.operacion_i;
            inv_q   <= bus.invert_i | (bus.operacion_i == OP_SLT);
            carry_q <= bus.invert_i | (bus.operacion_i == OP_SLT);
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cout;
          acc_q   <= acc_nxt;
          if (!last) cnt_q <= cnt_q + CW'(1);
          if (last) begin
            res_q  <= res_fin;
            zero_q <= (res_fin == '0);
            cout_q <= arith & cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;

  // In the MSB cycle carry_q is the carry into the MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   ovf_q <= 1'b0;
    else if (state == RUN && last) ovf_q <= arith & (carry_q ^ cout);
  end

  assign bus.overflow_o = ovf_q;
`else
  assign bus.overflow_o = 1'b0;
`endif

  assign bus.ready_o     = (state == IDLE);
  assign bus.valid_o     = (state == DONE);
  assign bus.resultado_o = res_q;
  assign bus.zero_o      = zero_q;
  assign bus.carry_o     = cout_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expectations queued at acceptance, compared at valid_o.
module tb_alu_serial_seq;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        inv;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned last_acc = 0;
  bit          burst = 1'b0;
  exp_t        exp_q[$];
  int unsigned acc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic inv, input logic [2:0] op);
    exp_t        e;
    logic        inv_e;
    logic [31:0] bb;
    logic [32:0] s;
    inv_e = inv | (op == 3'b011);
    bb    = inv_e ? ~b : b;
    s     = {1'b0, a} + {1'b0, bb} + {32'd0, inv_e};
    e     = '0;
    case (op)
      3'b000: e.res = a & bb;
      3'b001: e.res = a | bb;
      3'b010: e.res = s[31:0];
      3'b011: e.res = {31'd0, s[31]};
      3'b100: e.res = a ^ bb;
      default: e.res = '0;
    endcase
    e.z = (e.res == 32'd0);
    e.c = (op == 3'b010 || op == 3'b011) ? s[32] : 1'b0;
`ifdef ALU_SERIAL_OVF_EN
    e.v = (op == 3'b010 || op == 3'b011) && (a[31] == bb[31]) && (s[31] != a[31]);
`else
    e.v = 1'b0;
`endif
    return e;
  endfunction

  // Acceptance monitor: push expectation from inputs sampled at the accepting edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.valid_i && bus.ready_o) begin
      if (burst && last_acc != 0) check("spacing", cyc - last_acc, W + 2);
      last_acc = cyc;
      exp_q.push_back(model(bus.a_i, bus.b_i, bus.invert_i, bus.operacion_i));
      acc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    int unsigned t;
    if (rst_n && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check("latency", cyc - t, W);
        check("res", bus.resultado_o, e.res);
        check("zero", {31'd0, bus.zero_o}, {31'd0, e.z});
        check("carry", {31'd0, bus.carry_o}, {31'd0, e.c});
        check("ovf", {31'd0, bus.overflow_o}, {31'd0, e.v});
      end
      done_cnt++;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    acc_q.delete();
    last_acc = 0;
  end

  task automatic wait_ready();
    int unsigned i;
    for (i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.ready_o) break;
    end
    if (!bus.ready_o) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic inv, input logic [2:0] op);
    int unsigned n;
    n = done_cnt;
    wait_ready();
    bus.a_i = a;
    bus.b_i = b;
    bus.invert_i = inv;
    bus.operacion_i = op;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int i = 0; i < W + 8 && done_cnt == n; i++) @(negedge clk);
    #1;
    if (done_cnt == n) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_literal(input string tag, input vec_t v);
    logic ve;
`ifdef ALU_SERIAL_OVF_EN
    ve = v.v;
`else
    ve = 1'b0;
`endif
    check({tag, "_res"}, bus.resultado_o, v.res);
    check({tag, "_z"}, {31'd0, bus.zero_o}, {31'd0, v.z});
    check({tag, "_c"}, {31'd0, bus.carry_o}, {31'd0, v.c});
    check({tag, "_v"}, {31'd0, bus.overflow_o}, {31'd0, ve});
  endtask

  vec_t vecs[11] = '{
    '{32'd5,        32'd1 + 32'd6, 1'b0, 3'b010, 32'd12,       1'b0, 1'b0, 1'b0},
    '{32'h80000000, 32'd1,         1'b1, 3'b010, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1},
    '{32'd9,        32'd9,         1'b1, 3'b010, 32'd0,        1'b1, 1'b1, 1'b0},
    '{32'd3,        32'd5,         1'b0, 3'b011, 32'd1,        1'b0, 1'b0, 1'b0},
    '{32'd5,        32'd3,         1'b0, 3'b011, 32'd0,        1'b1, 1'b1, 1'b0},
    '{32'hF0F0F0F0, 32'hFF00FF00,  1'b0, 3'b000, 32'hF000F000, 1'b0, 1'b0, 1'b0},
    '{32'hF0F0F0F0, 32'hFF00FF00,  1'b0, 3'b100, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0},
    '{32'd5,        32'd3,         1'b0, 3'b111, 32'd0,        1'b1, 1'b0, 1'b0},
    '{32'hF0F0F0F0, 32'h0F0F0F0F,  1'b0, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'd1,         1'b0, 3'b010, 32'd0,        1'b1, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'd1,         1'b0, 3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    int unsigned n;
    bus.valid_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.invert_i = 1'b0;
    bus.operacion_i = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_res", bus.resultado_o, 32'd0);
    check("rst_flags", {29'd0, bus.zero_o, bus.carry_o, bus.overflow_o}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].inv, vecs[i].op);
      check_literal($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back requests with valid_i held high and operands changing every cycle.
    @(negedge clk);
    burst = 1'b1;
    last_acc = 0;
    bus.valid_i = 1'b1;
    repeat (6 * (W + 2) + 2) begin
      bus.a_i = $urandom;
      bus.b_i = $urandom;
      bus.invert_i = 1'($urandom_range(0, 1));
      bus.operacion_i = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    burst = 1'b0;
    for (int i = 0; i < 2 * W && exp_q.size() != 0; i++) @(negedge clk);
    check("burst_drain", exp_q.size(), 32'd0);
    check("burst_count", 32'(done_cnt >= 11 + 6), 32'd1);

    // Abort an ADD at bit cycle 10 with an asynchronous reset.
    run_op(32'd100, 32'd23, 1'b0, 3'b010);
    check("pre_abort_res", bus.resultado_o, 32'd123);
    wait_ready();
    n = done_cnt;
    bus.a_i = 32'd1000;
    bus.b_i = 32'd2000;
    bus.invert_i = 1'b0;
    bus.operacion_i = 3'b010;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready_o}, 32'd1);
    check("abort_valid", {31'd0, bus.valid_o}, 32'd0);
    check("abort_res", bus.resultado_o, 32'd0);
    check("abort_flags", {29'd0, bus.zero_o, bus.carry_o, bus.overflow_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", done_cnt, n);
    run_op(32'd40, 32'd2, 1'b0, 3'b010);
    check("post_abort_res", bus.resultado_o, 32'd42);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=1 expected=0");
    $fatal(1);
  end
endmodule
